// File: rtl/puf_soc_piso.sv
// Parallel-in serial-out converter: one N_BIT word over valid/ready, streamed LSB-first.
// Optional trailing even-parity bit when PUF_SOC_PISO_PARITY_EN is defined.
module puf_soc_piso #(
    parameter int unsigned N_BIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_tx_valid,
    input  logic [N_BIT-1:0] i_tx_data,
    output logic             o_tx_ready,
    output logic             o_ser_valid,
    output logic             o_ser_data,
    input  logic             i_ser_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CW = (N_BIT > 1) ? $clog2(N_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef PUF_SOC_PISO_PARITY_EN
        PARITY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [N_BIT-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             tx_ready_n, ser_valid_n, ser_data_n, busy_n, done_n;
`ifdef PUF_SOC_PISO_PARITY_EN
    logic             parity, parity_n;
`endif

    // State, datapath and output registers; outputs are precomputed from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            o_tx_ready  <= 1'b1;
            o_ser_valid <= 1'b0;
            o_ser_data  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
`ifdef PUF_SOC_PISO_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            o_tx_ready  <= tx_ready_n;
            o_ser_valid <= ser_valid_n;
            o_ser_data  <= ser_data_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
`ifdef PUF_SOC_PISO_PARITY_EN
            parity      <= parity_n;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
`ifdef PUF_SOC_PISO_PARITY_EN
        parity_n = parity;
`endif
        if (i_clear) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_tx_valid) begin
                        shreg_n = i_tx_data;
                        cnt_n   = '0;
                        state_n = SHIFT;
`ifdef PUF_SOC_PISO_PARITY_EN
                        parity_n = ^i_tx_data;
`endif
                    end
                end
                // o_ser_valid is always high here, so ready alone means a transfer.
                SHIFT: begin
                    if (i_ser_ready) begin
                        shreg_n = shreg >> 1;
                        if (cnt == CW'(N_BIT - 1)) begin
`ifdef PUF_SOC_PISO_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = DONE;
`endif
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
`ifdef PUF_SOC_PISO_PARITY_EN
                PARITY: begin
                    if (i_ser_ready) state_n = DONE;
                end
`endif
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        tx_ready_n  = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
        done_n      = (state_n == DONE);
        ser_valid_n = 1'b0;
        ser_data_n  = 1'b0;
        if (state_n == SHIFT) begin
            ser_valid_n = 1'b1;
            ser_data_n  = shreg_n[0];
        end
`ifdef PUF_SOC_PISO_PARITY_EN
        if (state_n == PARITY) begin
            ser_valid_n = 1'b1;
            ser_data_n  = parity_n;
        end
`endif
    end

endmodule
